// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster counter sequencer for the VGA output path.
// Produces hcount/vcount plus sync, blanking and line/frame markers. All
// outputs are registered from the next-state counts, so every flag lines up
// with the hcount/vcount values it describes.
`timescale 1ns/1ps

module vga_timing_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  // Must be wide enough to hold H_TOTAL-1 and V_TOTAL-1.
  parameter int CW       = 11
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          restart,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          end_of_line,
  output logic          end_of_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries expressed at counter width so every compare is CW bits wide.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BLK_BEG  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_BLK_BEG  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_hblnk;
  logic          r_vblnk;
  logic          r_eol;
  logic          r_eof;

  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic          w_hsync_next;
  logic          w_vsync_next;
  logic          w_hblnk_next;
  logic          w_vblnk_next;
  logic          w_eol_next;
  logic          w_eof_next;

  // Next raster position: restart wins, then hold when disabled, then advance.
  always_comb begin
    // NOTE: defaults assigned first so every path drives every output;
    // otherwise the synthesizer infers latches for the unassigned paths.
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    if (restart) begin
      w_h_next = '0;
      w_v_next = '0;
    end else if (en) begin
      if (r_hcount == H_LAST) begin
        w_h_next = '0;
        if (r_vcount == V_LAST) begin
          w_v_next = '0;
        end else begin
          w_v_next = r_vcount + 1'b1;
        end
      end else begin
        w_h_next = r_hcount + 1'b1;
      end
    end
  end

  // Decode flags from the next position. Holding the counts holds the flags,
  // and position (0,0) decodes to all-zero flags, matching the reset state.
  always_comb begin
    w_hsync_next = (w_h_next >= H_SYNC_BEG) && (w_h_next < H_SYNC_END);
    w_vsync_next = (w_v_next >= V_SYNC_BEG) && (w_v_next < V_SYNC_END);
    w_hblnk_next = (w_h_next >= H_BLK_BEG);
    w_vblnk_next = (w_v_next >= V_BLK_BEG);
    w_eol_next   = (w_h_next == H_LAST);
    w_eof_next   = (w_h_next == H_LAST) && (w_v_next == V_LAST);
  end

  // Counter and flag registers; async reset returns the raster to (0,0).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_eol    <= 1'b0;
      r_eof    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_hsync  <= w_hsync_next;
      r_vsync  <= w_vsync_next;
      r_hblnk  <= w_hblnk_next;
      r_vblnk  <= w_vblnk_next;
      r_eol    <= w_eol_next;
      r_eof    <= w_eof_next;
    end
  end

  assign hcount       = r_hcount;
  assign vcount       = r_vcount;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign hblnk        = r_hblnk;
  assign vblnk        = r_vblnk;
  assign end_of_line  = r_eol;
  assign end_of_frame = r_eof;

endmodule
